// File: rtl/mips_pkg.sv
// Shared constants for the MIPS execute/memory slice.
// Contents: word width and the 3-bit ALU operation encodings.
package mips_pkg;

  localparam int DATA_W = 32;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

endpackage

// File: rtl/exec_alu.sv
// Combinational ALU with zero flag.
// Ports:
//   i_a, i_b  : 32-bit operands
//   i_op      : 3-bit operation select (mips_pkg ALU_* codes)
//   o_result  : operation result, 0 for undefined codes
//   o_zero    : high when o_result == 0
module exec_alu
  import mips_pkg::*;
(
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  input  logic [2:0]        i_op,
  output logic [DATA_W-1:0] o_result,
  output logic              o_zero
);

  logic signed [DATA_W-1:0] w_a_s;
  logic signed [DATA_W-1:0] w_b_s;
  logic                     w_slt;

  assign w_a_s = i_a;
  assign w_b_s = i_b;
  assign w_slt = (w_a_s < w_b_s);

  always_comb begin
    o_result = '0;
    case (i_op)
      ALU_AND: o_result = i_a & i_b;
      ALU_OR:  o_result = i_a | i_b;
      ALU_ADD: o_result = i_a + i_b;
      ALU_SUB: o_result = i_a - i_b;
      ALU_SLT: o_result = {{(DATA_W-1){1'b0}}, w_slt};
      default: o_result = '0;
    endcase
  end

  assign o_zero = (o_result == '0);

endmodule

// File: rtl/exec_mem_unit.sv
// Execute/memory slice of a single-cycle MIPS datapath: free-standing adder
// (PC+4 / branch target), ALU with zero flag, and a word-organised data
// memory addressed by the ALU result.
// Ports:
//   clk, rst            : clock (writes on rising edge), async active-low reset
//   add_a, add_b        : adder operands; add_sum = add_a + add_b
//   alu_a, alu_b, alu_op: ALU inputs; alu_result, zero outputs
//   mem_read, mem_write : read / write enables
//   mem_wdata           : store data; mem_rdata : load data (0 when not reading)
//   out1, out2          : continuous views of the words at OUT1_ADDR / OUT2_ADDR
module exec_mem_unit
  import mips_pkg::*;
#(
  parameter int MEM_WORDS = 1024,
  parameter int OUT1_ADDR = 2000,
  parameter int OUT2_ADDR = 2004
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] add_a,
  input  logic [DATA_W-1:0] add_b,
  output logic [DATA_W-1:0] add_sum,
  input  logic [DATA_W-1:0] alu_a,
  input  logic [DATA_W-1:0] alu_b,
  input  logic [2:0]        alu_op,
  output logic [DATA_W-1:0] alu_result,
  output logic              zero,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] out1,
  output logic [DATA_W-1:0] out2
);

  localparam int AW       = $clog2(MEM_WORDS);
  // Observation addresses wrap the same way as normal accesses.
  localparam int OUT1_IDX = (OUT1_ADDR / 4) % MEM_WORDS;
  localparam int OUT2_IDX = (OUT2_ADDR / 4) % MEM_WORDS;

  logic [DATA_W-1:0] r_mem [MEM_WORDS];
  logic [AW-1:0]     w_idx;

  assign add_sum = add_a + add_b;

  exec_alu u_alu (
    .i_a      (alu_a),
    .i_b      (alu_b),
    .i_op     (alu_op),
    .o_result (alu_result),
    .o_zero   (zero)
  );

  // Byte address -> word index; low two bits and bits above the array are dropped.
  assign w_idx = alu_result[AW+1:2];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < MEM_WORDS; i++) r_mem[i] <= '0;
    end else if (mem_write) begin
      r_mem[w_idx] <= mem_wdata;
    end
  end

  assign mem_rdata = mem_read ? r_mem[w_idx] : '0;
  assign out1      = r_mem[OUT1_IDX];
  assign out2      = r_mem[OUT2_IDX];

endmodule

// File: tb/tb_exec_mem_unit.sv
module tb_exec_mem_unit;
  import mips_pkg::*;

  localparam int MEM_WORDS = 1024;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] add_a, add_b, add_sum;
  logic [31:0] alu_a, alu_b, alu_result;
  logic [2:0]  alu_op;
  logic        zero;
  logic        mem_read, mem_write;
  logic [31:0] mem_wdata, mem_rdata, out1, out2;

  int applied = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  exec_mem_unit #(.MEM_WORDS(MEM_WORDS), .OUT1_ADDR(2000), .OUT2_ADDR(2004)) dut (
    .clk        (clk),
    .rst        (rst),
    .add_a      (add_a),
    .add_b      (add_b),
    .add_sum    (add_sum),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op     (alu_op),
    .alu_result (alu_result),
    .zero       (zero),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .out1       (out1),
    .out2       (out2)
  );

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_res;
    logic        exp_zero;
  } alu_vec_t;

  typedef struct {
    string       name;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_sum;
  } add_vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    applied++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive ALU so alu_result equals the given byte address.
  task automatic set_addr(input logic [31:0] addr);
    alu_op = ALU_ADD;
    alu_a  = addr;
    alu_b  = 32'd0;
  endtask

  alu_vec_t alu_tbl [10];
  add_vec_t add_tbl [2];

  initial begin
    add_tbl[0] = '{"add_wrap", 32'hFFFF_FFFC, 32'd4, 32'd0};
    add_tbl[1] = '{"add_pc4",  32'd100,       32'd4, 32'd104};

    alu_tbl[0] = '{"alu_and",   ALU_AND, 32'd7, 32'd5, 32'd5,  1'b0};
    alu_tbl[1] = '{"alu_or",    ALU_OR,  32'd7, 32'd5, 32'd7,  1'b0};
    alu_tbl[2] = '{"alu_add",   ALU_ADD, 32'd7, 32'd5, 32'd12, 1'b0};
    alu_tbl[3] = '{"alu_sub",   ALU_SUB, 32'd7, 32'd5, 32'd2,  1'b0};
    alu_tbl[4] = '{"alu_slt0",  ALU_SLT, 32'd7, 32'd5, 32'd0,  1'b1};
    alu_tbl[5] = '{"alu_slt1",  ALU_SLT, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0};
    alu_tbl[6] = '{"alu_subz",  ALU_SUB, 32'd9, 32'd9, 32'd0,  1'b1};
    alu_tbl[7] = '{"alu_op011", 3'b011,  32'd7, 32'd5, 32'd0,  1'b1};
    alu_tbl[8] = '{"alu_subwr", ALU_SUB, 32'd0, 32'd1, 32'hFFFF_FFFF, 1'b0};
    alu_tbl[9] = '{"alu_sltn",  ALU_SLT, 32'd1, 32'h8000_0000, 32'd0, 1'b1};

    rst = 1'b0;
    add_a = '0; add_b = '0;
    alu_a = '0; alu_b = '0; alu_op = ALU_ADD;
    mem_read = 1'b0; mem_write = 1'b0; mem_wdata = '0;

    // Reset state
    #2;
    check("rst_out1", out1, 32'd0);
    check("rst_out2", out2, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Adder vectors (also checked while ALU varies below)
    foreach (add_tbl[i]) begin
      add_a = add_tbl[i].a;
      add_b = add_tbl[i].b;
      #1;
      check(add_tbl[i].name, add_sum, add_tbl[i].exp_sum);
    end

    // ALU table
    foreach (alu_tbl[i]) begin
      alu_op = alu_tbl[i].op;
      alu_a  = alu_tbl[i].a;
      alu_b  = alu_tbl[i].b;
      #1;
      check({alu_tbl[i].name, "_res"}, alu_result, alu_tbl[i].exp_res);
      check({alu_tbl[i].name, "_zero"}, {31'd0, zero}, {31'd0, alu_tbl[i].exp_zero});
    end

    // Write DEADBEEF at 2000, read back
    @(negedge clk);
    set_addr(32'd2000);
    mem_wdata = 32'hDEADBEEF;
    mem_write = 1'b1;
    @(negedge clk);
    mem_write = 1'b0;
    mem_read  = 1'b1;
    #1;
    check("rd_2000", mem_rdata, 32'hDEADBEEF);
    check("out1_wr", out1, 32'hDEADBEEF);
    mem_read = 1'b0;
    #1;
    check("rd_disabled", mem_rdata, 32'd0);

    // Write 42 at 2004
    @(negedge clk);
    set_addr(32'd2004);
    mem_wdata = 32'd42;
    mem_write = 1'b1;
    @(negedge clk);
    mem_write = 1'b0;
    #1;
    check("out2_wr", out2, 32'd42);
    check("out1_kept", out1, 32'hDEADBEEF);
    mem_read = 1'b1;
    set_addr(32'd2005);
    #1;
    check("rd_2005", mem_rdata, 32'd42);
    set_addr(32'd2004 + MEM_WORDS * 4);
    #1;
    check("rd_alias", mem_rdata, 32'd42);
    set_addr(32'd2008);
    #1;
    check("rd_2008", mem_rdata, 32'd0);

    // Same-address read and write in one cycle
    @(negedge clk);
    set_addr(32'd2004);
    mem_read  = 1'b1;
    mem_write = 1'b1;
    mem_wdata = 32'd77;
    #1;
    check("rw_old", mem_rdata, 32'd42);
    @(posedge clk);
    #1;
    check("rw_new", mem_rdata, 32'd77);
    mem_write = 1'b0;
    check("out2_rw", out2, 32'd77);

    // Reset mid-cycle with a pending write
    @(negedge clk);
    set_addr(32'd2000);
    mem_wdata = 32'd55;
    mem_write = 1'b1;
    #2;
    rst = 1'b0;
    #1;
    check("mid_rst_out1", out1, 32'd0);
    check("mid_rst_out2", out2, 32'd0);
    check("mid_rst_rd", mem_rdata, 32'd0);
    add_a = 32'd100; add_b = 32'd4;
    #1;
    check("rst_add", add_sum, 32'd104);
    check("rst_alu", alu_result, 32'd2000);
    @(posedge clk);
    #1;
    check("rst_wr_block", out1, 32'd0);
    @(negedge clk);
    mem_write = 1'b0;
    rst = 1'b1;
    #1;
    check("post_rst_rd", mem_rdata, 32'd0);

    // First write after release
    @(negedge clk);
    mem_wdata = 32'h0000_1234;
    mem_write = 1'b1;
    @(negedge clk);
    mem_write = 1'b0;
    #1;
    check("post_rst_wr", out1, 32'h0000_1234);
    check("post_rst_rd2", mem_rdata, 32'h0000_1234);

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
